// File: rtl/rc_pkg.sv
// ---------------------------------------------------------------------------
// rc_pkg: shared formats and saturation patterns for the RC TX/RX filters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rc_pkg;

  localparam int RC_NB_SAMPLE   = 8;
  localparam int RC_NBF_SAMPLE  = 7;
  localparam int RC_NB_COEFFS   = 8;
  localparam int RC_NBF_COEFFS  = 7;
  localparam int RC_N_COEFFS    = 6;
  localparam int RC_NB_OUTPUT   = 8;
  localparam int RC_NBF_OUTPUT  = 7;
  localparam int RC_OS_FACTOR   = 4;
  localparam int RC_NB_PHASE    = 2;

  localparam logic [RC_NB_OUTPUT-1:0] SAT_POS = {1'b0, {(RC_NB_OUTPUT-1){1'b1}}};
  localparam logic [RC_NB_OUTPUT-1:0] SAT_NEG = {1'b1, {(RC_NB_OUTPUT-1){1'b0}}};

  // Three guard bits cover the growth of up to eight summed products.
  function automatic int nb_adder(input int nb_s, input int nb_c);
    return nb_s + nb_c + 3;
  endfunction

  function automatic int nbf_adder(input int nbf_s, input int nbf_c);
    return nbf_s + nbf_c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rc_sat_trunc.sv
// ---------------------------------------------------------------------------
// rc_sat_trunc: combinational fractional truncation and integer saturation. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rc_sat_trunc #(
  parameter int NB_IN   = 19,
  parameter int NBF_IN  = 14,
  parameter int NB_OUT  = 8,
  parameter int NBF_OUT = 7
) (
  input  logic [NB_IN-1:0]  i_data,
  output logic [NB_OUT-1:0] o_data,
  output logic              o_nonneg
);

  localparam int NB_TR = NB_IN - (NBF_IN - NBF_OUT);
  localparam int NB_HI = NB_TR - NB_OUT + 1;
  localparam logic signed [NB_IN-1:0] c_zero = '0;

  logic [NB_TR-1:0] w_trunc;
  logic [NB_HI-1:0] w_hi;
  logic             w_ovf;

  assign w_trunc  = i_data[NB_IN-1 -: NB_TR];
  assign w_hi     = w_trunc[NB_TR-1 -: NB_HI];
  // In range only when the dropped integer bits all replicate the kept sign bit.
  assign w_ovf    = ~((&w_hi) | ~(|w_hi));
  assign o_nonneg = ($signed(i_data) >= c_zero);

  always_comb begin
    o_data = w_trunc[NB_OUT-1:0];
    if (w_ovf) begin
      if (w_trunc[NB_TR-1]) o_data = {1'b1, {(NB_OUT-1){1'b0}}};
      else                  o_data = {1'b0, {(NB_OUT-1){1'b1}}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/rc_rx.sv
// ---------------------------------------------------------------------------
// rc_rx: BPSK raised-cosine matched FIR, decimator and slicer. Rev 1.0
// Soft (saturated) filter output is built only with RC_RX_SOFT_OUT_EN defined.
// ---------------------------------------------------------------------------
`default_nettype none

module rc_rx
  import rc_pkg::*;
#(
  parameter int NB_SAMPLE  = RC_NB_SAMPLE,
  parameter int NB_COEFFS  = RC_NB_COEFFS,
  parameter int N_COEFFS   = RC_N_COEFFS,
`ifdef RC_RX_SOFT_OUT_EN
  parameter int NBF_SAMPLE = RC_NBF_SAMPLE,
  parameter int NBF_COEFFS = RC_NBF_COEFFS,
  parameter int NB_OUTPUT  = RC_NB_OUTPUT,
  parameter int NBF_OUTPUT = RC_NBF_OUTPUT,
`endif
  parameter int OS_FACTOR  = RC_OS_FACTOR,
  parameter int NB_PHASE   = RC_NB_PHASE
) (
  input  logic                          clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic                          i_valid,
  input  logic [NB_SAMPLE-1:0]          i_sample,
  input  logic [N_COEFFS*NB_COEFFS-1:0] i_coeffs,
  input  logic [NB_PHASE-1:0]           i_phase,
  output logic                          o_bit,
  output logic                          o_bit_valid
`ifdef RC_RX_SOFT_OUT_EN
  ,
  output logic [NB_OUTPUT-1:0]          o_filt
`endif
);

  localparam int NB_PROD  = NB_SAMPLE + NB_COEFFS;
  localparam int NB_ADDER = nb_adder(NB_SAMPLE, NB_COEFFS);

  logic signed [NB_SAMPLE-1:0] r_dly  [N_COEFFS];
  logic signed [NB_COEFFS-1:0] w_coef [N_COEFFS];
  logic signed [NB_PROD-1:0]   r_prod [N_COEFFS];
  logic [NB_PHASE-1:0]         r_cnt;
  logic                        r_hit0;
  logic                        r_hit1;
  logic signed [NB_ADDER-1:0]  w_sum;
  logic                        w_nonneg;

  for (genvar k = 0; k < N_COEFFS; k++) begin : g_coef
    assign w_coef[k] = i_coeffs[(k+1)*NB_COEFFS-1 -: NB_COEFFS];
  end

  // Delay line, phase counter and hit tag; the tag uses the pre-increment count.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < N_COEFFS; k++) r_dly[k] <= '0;
      r_cnt  <= '0;
      r_hit0 <= 1'b0;
    end else if (i_enable) begin
      r_hit0 <= i_valid & (r_cnt == i_phase);
      if (i_valid) begin
        r_dly[0] <= i_sample;
        for (int k = 1; k < N_COEFFS; k++) r_dly[k] <= r_dly[k-1];
        r_cnt <= (r_cnt == NB_PHASE'(OS_FACTOR-1)) ? '0 : r_cnt + NB_PHASE'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < N_COEFFS; k++) r_prod[k] <= '0;
      r_hit1 <= 1'b0;
    end else if (i_enable) begin
      for (int k = 0; k < N_COEFFS; k++) r_prod[k] <= NB_PROD'(r_dly[k]) * NB_PROD'(w_coef[k]);
      r_hit1 <= r_hit0;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N_COEFFS; k++) w_sum = w_sum + NB_ADDER'(r_prod[k]);
  end

`ifdef RC_RX_SOFT_OUT_EN
  logic [NB_OUTPUT-1:0] w_sat;

  rc_sat_trunc #(
    .NB_IN   (NB_ADDER),
    .NBF_IN  (nbf_adder(NBF_SAMPLE, NBF_COEFFS)),
    .NB_OUT  (NB_OUTPUT),
    .NBF_OUT (NBF_OUTPUT)
  ) u_sat (
    .i_data   (w_sum),
    .o_data   (w_sat),
    .o_nonneg (w_nonneg)
  );

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)                o_filt <= '0;
    else if (i_enable && r_hit1) o_filt <= w_sat;
  end
`else
  localparam logic signed [NB_ADDER-1:0] c_zero = '0;
  assign w_nonneg = (w_sum >= c_zero);
`endif

  // Zero slices to 1 to match the transmit mapping (bit 1 selects +coeff).
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_bit       <= 1'b0;
      o_bit_valid <= 1'b0;
    end else if (!i_enable) begin
      o_bit_valid <= 1'b0;
    end else begin
      o_bit_valid <= r_hit1;
      if (r_hit1) o_bit <= w_nonneg;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rc_rx.sv
// ---------------------------------------------------------------------------
// tb_rc_rx: randomized scoreboard bench for rc_rx against an arithmetic model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rc_rx;

  localparam int N  = 6;
  localparam int OS = 4;

  logic        clock    = 1'b0;
  logic        i_reset  = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_valid  = 1'b0;
  logic [7:0]  i_sample = '0;
  logic [47:0] i_coeffs = '0;
  logic [1:0]  i_phase  = '0;
  logic        o_bit;
  logic        o_bit_valid;
`ifdef RC_RX_SOFT_OUT_EN
  logic [7:0]  o_filt;
`endif

  always #5 clock = ~clock;

  rc_rx dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_sample    (i_sample),
    .i_coeffs    (i_coeffs),
    .i_phase     (i_phase),
    .o_bit       (o_bit),
    .o_bit_valid (o_bit_valid)
`ifdef RC_RX_SOFT_OUT_EN
    ,
    .o_filt      (o_filt)
`endif
  );

  typedef struct {
    bit     b;
    int     filt;
    longint en;
  } exp_t;

  exp_t   q[$];
  int     checks   = 0;
  int     failures = 0;
  longint en_cnt   = 0;
  int     hist[N];
  int     mcnt;
  bit     last_bit = 1'b0;

  // Counts enabled clock edges; an accepted sample emerges two enabled edges later.
  always @(posedge clock) if (i_enable) en_cnt <= en_cnt + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int coef(input int k);
    logic [7:0] c;
    c = i_coeffs[k*8 +: 8];
    return $signed(c);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) hist[k] = 0;
    mcnt = 0;
    q.delete();
  endtask

  task automatic model_accept(input int s, input int ph);
    int   sum;
    int   f;
    bit   hit;
    exp_t e;
    for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    hit  = (mcnt == ph);
    mcnt = (mcnt + 1) % OS;
    if (hit) begin
      sum = 0;
      for (int k = 0; k < N; k++) sum += hist[k] * coef(k);
      f = sum >>> 7;
      if (f > 127)  f = 127;
      if (f < -128) f = -128;
      e.b    = (sum >= 0);
      e.filt = f;
      e.en   = en_cnt + 3;
      q.push_back(e);
    end
  endtask

  task automatic drive(input bit en, input bit v, input logic [7:0] s);
    i_enable = en;
    i_valid  = v;
    i_sample = s;
    if (en && v) model_accept($signed(s), int'(i_phase));
    @(posedge clock);
    #1;
  endtask

  task automatic flush();
    repeat (4) drive(1'b1, 1'b0, 8'h00);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (i_reset && o_bit_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=1 expected=0");
      end else begin
        e = q.pop_front();
        chk("bit", longint'(o_bit), longint'(e.b));
        chk("pulse_time", en_cnt, e.en);
`ifdef RC_RX_SOFT_OUT_EN
        chk("filt", longint'($signed(o_filt)), longint'(e.filt));
`endif
        last_bit = e.b;
      end
    end
  end

  initial begin
    model_reset();
    i_coeffs = {6{8'h40}};
    #2 i_reset = 1'b0;
    #10;
    chk("rst_bit", longint'(o_bit), 0);
    chk("rst_valid", longint'(o_bit_valid), 0);
`ifdef RC_RX_SOFT_OUT_EN
    chk("rst_filt", longint'(o_filt), 0);
`endif
    @(posedge clock);
    #1 i_reset = 1'b1;

    // Single hit sample: strobe must appear exactly after the second following edge.
    i_phase = 2'd0;
    drive(1'b1, 1'b1, 8'h40);
    chk("lat_e0", longint'(o_bit_valid), 0);
    drive(1'b1, 1'b0, 8'h00);
    chk("lat_e1", longint'(o_bit_valid), 0);
    drive(1'b1, 1'b0, 8'h00);
    chk("lat_e2", longint'(o_bit_valid), 1);
    chk("lat_bit", longint'(o_bit), 1);
    flush();

    repeat (40) drive(1'b1, 1'b1, 8'h40);
    chk("pos_sat_bit", longint'(o_bit), 1);
`ifdef RC_RX_SOFT_OUT_EN
    chk("pos_sat_filt", longint'(o_filt), 32'h7F);
`endif
    flush();

    repeat (40) drive(1'b1, 1'b1, 8'h80);
    chk("neg_sat_bit", longint'(o_bit), 0);
`ifdef RC_RX_SOFT_OUT_EN
    chk("neg_sat_filt", longint'(o_filt), 32'h80);
`endif
    flush();

    i_coeffs = 48'h0000_0000_0020;
    repeat (40) drive(1'b1, 1'b1, 8'h40);
    chk("inrange_bit", longint'(o_bit), 1);
`ifdef RC_RX_SOFT_OUT_EN
    chk("inrange_filt", longint'(o_filt), 32'h10);
`endif
    repeat (40) drive(1'b1, 1'b1, 8'h00);
    chk("zero_bit", longint'(o_bit), 1);
`ifdef RC_RX_SOFT_OUT_EN
    chk("zero_filt", longint'(o_filt), 0);
`endif
    flush();

    i_coeffs[31:0]  = $urandom();
    i_coeffs[47:32] = 16'($urandom());
    repeat (13) drive(1'b1, 1'b1, 8'($urandom()));
    i_phase = 2'd2;
    repeat (24) drive(1'b1, 1'b1, 8'($urandom()));

    // Stall with i_valid high: no strobes, bit holds, count frozen.
    repeat (3) drive(1'b1, 1'b1, 8'($urandom()));
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'($urandom()));
      chk("stall_valid", longint'(o_bit_valid), 0);
      chk("stall_bit", longint'(o_bit), longint'(last_bit));
    end
    repeat (12) drive(1'b1, 1'b1, 8'($urandom()));

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) i_phase = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 8'($urandom()));
    end
    flush();

    // Mid-stream asynchronous reset with samples still in flight.
    i_coeffs = {6{8'h40}};
    i_phase  = 2'd0;
    repeat (10) drive(1'b1, 1'b1, 8'h40);
    #2 i_reset = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("mid_rst_bit", longint'(o_bit), 0);
    chk("mid_rst_valid", longint'(o_bit_valid), 0);
`ifdef RC_RX_SOFT_OUT_EN
    chk("mid_rst_filt", longint'(o_filt), 0);
`endif
    model_reset();
    repeat (2) @(posedge clock);
    #1 i_reset = 1'b1;
    repeat (20) drive(1'b1, 1'b1, 8'($urandom()));

    repeat (6) drive(1'b1, 1'b0, 8'h00);
    chk("queue_empty", longint'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
